// File: rtl/pll_clken_gen.sv
// Clock-enable generator in the PLL output domain: qualifies PLL lock, sequences a
// downstream reset and produces phase-aligned per-channel enable strobes.
module pll_clken_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    div_load,
  input  logic                    clear_sticky,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready,
  output logic                    rst_out_n,
  output logic                    unlock_sticky,
  output logic [7:0]              unlock_count
);

  localparam int unsigned QW = $clog2(LOCK_CYCLES);
  localparam int unsigned CW = DIV_W + 1;
  localparam logic [QW-1:0] QLAST = QW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [DIV_W-1:0]       cnt_q    [NUM_CH];
  logic [DIV_W-1:0]       cnt_d    [NUM_CH];
  logic [DIV_W-1:0]       shadow_q [NUM_CH];
  logic [DIV_W-1:0]       ratio;
  logic [CW-1:0]          cnt_inc;
  logic [NUM_CH-1:0]      ce_d;
  logic                   lost;
  logic                   sticky_d;
  logic [7:0]             count_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock qualification sequencing
  always_comb begin
    state_d = state_q;
    qcnt_d  = '0;
    lost    = 1'b0;
    unique case (state_q)
      WAIT_LOCK: if (locked_s) state_d = QUALIFY;
      QUALIFY: begin
        if (!locked_s)           state_d = WAIT_LOCK;
        else if (qcnt_q == QLAST) state_d = RUN;
        else                     qcnt_d  = qcnt_q + QW'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Channel counters free-run only while staying in RUN; a load realigns them all
  always_comb begin
    ratio   = '0;
    cnt_inc = '0;
    ce_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ratio    = (shadow_q[i] == '0) ? DIV_W'(1) : shadow_q[i];
      cnt_inc  = {1'b0, cnt_q[i]} + CW'(1);
      cnt_d[i] = '0;
      if ((state_q == RUN) && (state_d == RUN) && !div_load && (cnt_inc < {1'b0, ratio}))
        cnt_d[i] = cnt_inc[DIV_W-1:0];
      ce_d[i] = (state_d == RUN) && (cnt_d[i] == '0);
    end
  end

  // Loss-of-lock bookkeeping; a simultaneous loss beats a clear
  always_comb begin
    sticky_d = unlock_sticky;
    count_d  = unlock_count;
    if (lost) begin
      sticky_d = 1'b1;
      if (clear_sticky)              count_d = 8'd1;
      else if (unlock_count != 8'hFF) count_d = unlock_count + 8'd1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
      count_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      sync_q        <= '0;
      qcnt_q        <= '0;
      ce            <= '0;
      ready         <= 1'b0;
      rst_out_n     <= 1'b0;
      unlock_sticky <= 1'b0;
      unlock_count  <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= DIV_W'(1);
      end
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      qcnt_q        <= qcnt_d;
      ce            <= ce_d;
      ready         <= (state_d == RUN);
      rst_out_n     <= (state_d == RUN);
      unlock_sticky <= sticky_d;
      unlock_count  <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (div_load) shadow_q[i] <= div[i*DIV_W +: DIV_W];
      end
    end
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Bench for pll_clken_gen: streak/age based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pll_clken_gen;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int SYNC_STAGES = 2;
  localparam int QUAL        = LOCK_CYCLES + 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    pll_locked = 1'b0;
  logic                    div_load = 1'b0;
  logic                    clear_sticky = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div = '0;
  logic [NUM_CH-1:0]       ce;
  logic                    ready;
  logic                    rst_out_n;
  logic                    unlock_sticky;
  logic [7:0]              unlock_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_clken_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .div(div),
    .div_load(div_load), .clear_sticky(clear_sticky), .ce(ce), .ready(ready),
    .rst_out_n(rst_out_n), .unlock_sticky(unlock_sticky), .unlock_count(unlock_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ready follows the run length of synchronised lock samples,
  // each ce follows the cycle age since the last alignment point modulo its ratio.
  logic              h0, h1, m_ready, m_sticky;
  int                streak, age, m_count;
  int                shadow [NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  int                st_n, age_n;
  int                dv [NUM_CH];
  logic              rdy_n;
  logic [NUM_CH-1:0] ce_n;

  always_comb begin
    st_n  = h1 ? streak + 1 : 0;
    rdy_n = (st_n >= QUAL);
    age_n = (div_load || (rdy_n && !m_ready)) ? 0 : age + 1;
    ce_n  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dv[i] = div_load ? int'(div[i*DIV_W +: DIV_W]) : shadow[i];
      if (dv[i] == 0) dv[i] = 1;
      ce_n[i] = rdy_n && ((age_n % dv[i]) == 0);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 <= 1'b0; h1 <= 1'b0; streak <= 0; age <= 0;
      m_ready <= 1'b0; m_ce <= '0; m_sticky <= 1'b0; m_count <= 0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= 1;
    end else begin
      h0 <= pll_locked; h1 <= h0;
      streak <= st_n; age <= age_n; m_ready <= rdy_n; m_ce <= ce_n;
      for (int i = 0; i < NUM_CH; i++)
        if (div_load) shadow[i] <= int'(div[i*DIV_W +: DIV_W]);
      if (m_ready && !h1) begin
        m_sticky <= 1'b1;
        m_count  <= clear_sticky ? 1 : ((m_count == 255) ? 255 : m_count + 1);
      end else if (clear_sticky) begin
        m_sticky <= 1'b0;
        m_count  <= 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("ce",            32'(ce),            32'(m_ce));
    chk("ready",         32'(ready),         32'(m_ready));
    chk("rst_out_n",     32'(rst_out_n),     32'(m_ready));
    chk("unlock_sticky", 32'(unlock_sticky), 32'(m_sticky));
    chk("unlock_count",  32'(unlock_count),  32'(m_count));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input logic lvl, input int budget, output int n);
    n = 0;
    while (ready !== lvl && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ready !== lvl) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got ready=%0b after %0d cycles expected %0b", ready, n, lvl);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0, c1, c2, c3;

    // Reset values
    tick(3);
    chk("rst_ready",  32'(ready),         32'h0);
    chk("rst_rstout", 32'(rst_out_n),     32'h0);
    chk("rst_ce",     32'(ce),            32'h0);
    chk("rst_sticky", 32'(unlock_sticky), 32'h0);
    chk("rst_count",  32'(unlock_count),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load ratios {4,3,2,0} while waiting for lock, then lock
    @(negedge clk);
    div = {16'd4, 16'd3, 16'd2, 16'd0};
    div_load = 1'b1;
    @(posedge clk);
    #1 div_load = 1'b0;
    pll_locked = 1'b1;
    wait_ready(1'b1, 100, n);
    chk("lock_latency", 32'(n), 32'd19);
    chk("entry_ce", 32'(ce), 32'hF);
    chk("entry_rstout", 32'(rst_out_n), 32'h1);

    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 1) chk("ce_after_entry", 32'(ce), 32'h1);
      c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]); c3 += int'(ce[3]);
    end
    chk("ce_coincide_12", 32'(ce), 32'hF);
    chk("ch0_pulses", 32'(c0), 32'd12);
    chk("ch1_pulses", 32'(c1), 32'd6);
    chk("ch2_pulses", 32'(c2), 32'd4);
    chk("ch3_pulses", 32'(c3), 32'd3);

    // Mid-period reload: ch1 2 -> 5
    tick(1);
    @(negedge clk);
    div = {16'd4, 16'd3, 16'd5, 16'd0};
    div_load = 1'b1;
    chk("load_cycle_ce", 32'(ce), 32'h1);
    @(posedge clk);
    #1 div_load = 1'b0;
    chk("after_load_ce", 32'(ce), 32'hF);
    c0 = 0; c1 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      c0 += int'(ce[0]); c1 += int'(ce[1]);
    end
    chk("reload_ch1_pulses", 32'(c1), 32'd2);
    chk("reload_ch0_pulses", 32'(c0), 32'd10);

    // Asynchronous reset while running
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ce",     32'(ce),        32'h0);
    chk("async_ready",  32'(ready),     32'h0);
    chk("async_rstout", 32'(rst_out_n), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ready(1'b1, 100, n);
    chk("relock_latency", 32'(n), 32'd19);

    // Lock glitch during qualification
    @(negedge clk);
    #2 reset_n = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 pll_locked = 1'b1;
    tick(13);
    chk("glitch_not_ready", 32'(ready), 32'h0);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    wait_ready(1'b1, 100, n);
    chk("glitch_latency", 32'(n), 32'd19);
    chk("glitch_count",  32'(unlock_count),  32'h0);
    chk("glitch_sticky", 32'(unlock_sticky), 32'h0);

    // 300 losses of lock in RUN: count saturates
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_ready(1'b0, 10, n);
      wait_ready(1'b1, 40, n);
    end
    chk("sat_count",  32'(unlock_count),  32'd255);
    chk("sat_sticky", 32'(unlock_sticky), 32'h1);

    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    chk("clear_count",  32'(unlock_count),  32'h0);
    chk("clear_sticky", 32'(unlock_sticky), 32'h0);

    // Clear coinciding with a loss event: the event wins
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    chk("coincide_ready",  32'(ready),         32'h0);
    chk("coincide_sticky", 32'(unlock_sticky), 32'h1);
    chk("coincide_count",  32'(unlock_count),  32'h1);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_clken_gen.md
# pll_clken_gen

Parametrised clock-enable generator that runs in the PLL output clock domain of the Pyramic array design. It qualifies the asynchronous PLL lock indication over a programmable stable interval and sequences a downstream active-low reset. Once running, it derives NUM_CH phase-aligned clock-enable strobes with independently programmable integer divide ratios. It also detects loss of lock, records it sticky with a saturating event count, and replaces the fixed-ratio derived-clock approach with one fast clock plus enables.

## Interface
Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16)
- DIV_W, 16, width of each channel divide ratio
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before RUN (>=2)
- SYNC_STAGES, 2, synchroniser depth on pll_locked (>=2)

Ports:
- clk  in  1  PLL output clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- div  in  NUM_CH*DIV_W  per-channel ratio, channel i at [i*DIV_W +: DIV_W]
- div_load  in  1  single-cycle strobe; captures div into shadow registers and realigns all channels
- clear_sticky  in  1  clears unlock_sticky and unlock_count
- ce  out  NUM_CH  per-channel clock-enable strobes
- ready  out  1  high in RUN
- rst_out_n  out  1  active-low reset to downstream logic
- unlock_sticky  out  1  set on loss of lock in RUN
- unlock_count  out  8  saturating count of RUN-to-unlock events

## Operation
- Reset values: state=WAIT_LOCK, synchroniser=0, qualify counter=0, all channel counters=0, shadow ratios=1, ce=0, ready=0, rst_out_n=0, unlock_sticky=0, unlock_count=0.
- pll_locked passes through a SYNC_STAGES flip-flop chain and becomes locked_s. No other logic samples pll_locked directly.
- States:
  - WAIT_LOCK: qualify counter held at 0. Go to QUALIFY when locked_s=1.
  - QUALIFY: counter increments each cycle while locked_s=1. If locked_s=0, return to WAIT_LOCK and clear the counter. When the counter equals LOCK_CYCLES-1 with locked_s=1, go to RUN.
  - RUN: ready=1, rst_out_n=1, ce active. If locked_s=0, go to WAIT_LOCK, set unlock_sticky, and increment unlock_count, saturating at 255.
- Ratio rules:
  - A shadow ratio d produces one ce pulse every d cycles.
  - d=0 is treated as 1, so ce is high every cycle.
  - Each channel counter runs 0..d-1 and wraps to 0.
  - ce[i] = (state==RUN) && cnt[i]==0.
- Outside RUN, all channel counters are held at 0. The first RUN cycle therefore asserts every ce, giving phase alignment.
- div_load, in any state: shadows take div at the clock edge and all channel counters are forced to 0.
  - In the load cycle, ce still reflects the old counters.
  - The next cycle asserts every ce when in RUN.
- clear_sticky clears unlock_sticky and unlock_count. If clear_sticky coincides with a loss-of-lock event, the event wins: sticky ends at 1 and count ends at 1.
- ready, rst_out_n and ce are registered outputs with no combinational path from inputs.

## Timing
- pll_locked rising to locked_s: SYNC_STAGES cycles.
- locked_s rising to ready/rst_out_n high: LOCK_CYCLES+1 cycles, i.e. 1 cycle for WAIT_LOCK→QUALIFY plus LOCK_CYCLES in QUALIFY.
- locked_s falling in RUN: ready=0, rst_out_n=0 and ce=0 on the next cycle. unlock_sticky and unlock_count update on that same edge.
- A lock glitch shorter than the qualification interval during QUALIFY restarts qualification from zero.
- Asynchronous reset mid-operation forces all outputs to reset values immediately. Qualification restarts after reset_n deasserts.
- div_load asserted on the same cycle as entry into RUN: counters reset, so the first RUN cycle still asserts all ce, now using the new ratios.

## Test plan
- LOCK_CYCLES=16, SYNC_STAGES=2: raise pll_locked at cycle 0 → ready and rst_out_n rise at cycle 19 (2+1+16), and ce=4'b1111 on that cycle.
- Drop pll_locked for 3 cycles at qualification count 10, then reassert → WAIT_LOCK re-entered, ready delayed a full 17 cycles after locked_s returns, unlock_count stays 0.
- RUN with div={4,3,2,0} (ch3..ch0) → ce0 every cycle, ce1 every 2, ce2 every 3, ce3 every 4; all four coincide every 12 cycles.
- In RUN, pulse div_load with ch1 changed from 2 to 5 mid-period → load cycle shows the old pattern, next cycle ce=4'b1111, then ch1 pulses every 5 cycles.
- Drop pll_locked in RUN 300 times → unlock_count saturates at 255, unlock_sticky=1. Then clear_sticky → both 0 one cycle later.
- Assert reset_n=0 while in RUN with ce toggling → ce=0, ready=0, rst_out_n=0 immediately. After release with pll_locked held high, ready returns after 19 cycles.
